ram_sdp_clr: RTL and testbench
==============================

RAM_SDP_CLR -- requirements
Module: ram_sdp_clr

Interface
REQ-001 SHALL have parameter A_WIDTH, default 4, address width; depth = 2**A_WIDTH words.
REQ-002 SHALL have parameter D_WIDTH, default 8, word width in bits.
REQ-003 SHALL have parameter RD_LATENCY, default 1, read latency in cycles; legal values 1 or 2 only.
REQ-004 SHALL have parameter RDW_MODE, default 0, same-address read-during-write: 0 = old data, 1 = new data.
REQ-005 SHALL derive BE_WIDTH = (D_WIDTH+7)/8 byte lanes; lane k = bits [8k+7:8k]; top lane is partial when D_WIDTH is not a multiple of 8.
REQ-006 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-008 SHALL have port write_enable  input  1  write request.
REQ-009 SHALL have port address_write  input  A_WIDTH  write address.
REQ-010 SHALL have port data_write  input  D_WIDTH  write data.
REQ-011 SHALL have port byte_enable  input  BE_WIDTH  per-lane write mask.
REQ-012 SHALL have port read_enable  input  1  read request.
REQ-013 SHALL have port address_read  input  A_WIDTH  read address.
REQ-014 SHALL have port data_read  output  D_WIDTH  read data, registered.
REQ-015 SHALL have port read_valid  output  1  one-cycle strobe qualifying data_read.
REQ-016 SHALL have port clear  input  1  request to zero the whole array.
REQ-017 SHALL have port busy  output  1  clear engine active; user accesses ignored.

Function
REQ-018 SHALL implement a clear FSM with states CLEAR and IDLE, plus a clear pointer of A_WIDTH bits.
REQ-019 In CLEAR, SHALL write all-zero to the address held in the pointer each cycle and increment the pointer.
REQ-020 In CLEAR, SHALL move to IDLE on the cycle the word at address 2**A_WIDTH-1 is written; pointer wrap-around SHALL NOT start a second pass.
REQ-021 In IDLE, clear=1 SHALL move to CLEAR with pointer 0.
REQ-022 In CLEAR, clear=1 SHALL restart at pointer 0; a full clear SHALL then take 2**A_WIDTH further cycles.
REQ-023 busy SHALL be 1 exactly while the state is CLEAR (registered; no combinational path from clear).
REQ-024 While busy=1, write_enable and read_enable SHALL be ignored: no array write, and read_valid SHALL stay 0.
REQ-025 In IDLE, write_enable=1 SHALL update only the lanes whose byte_enable bit is 1; byte_enable=0 SHALL leave the word unchanged.
REQ-026 In IDLE, read_enable=1 at edge N SHALL give data_read = mem[address_read] and read_valid=1 after edge N+RD_LATENCY-1, i.e. valid RD_LATENCY cycles later.
REQ-027 Reads SHALL be fully pipelined; one read per cycle SHALL be sustained with no bubbles.
REQ-028 data_read SHALL hold its last value while read_valid=0.
REQ-029 For a same-cycle read and write to the same address, RDW_MODE=0 SHALL return the pre-write word.
REQ-030 For a same-cycle read and write to the same address, RDW_MODE=1 SHALL return the pre-write word with the enabled lanes replaced by data_write.
REQ-031 A read in flight when clear is accepted SHALL still complete with its pre-clear data.
REQ-032 Reads issued after a clear completes SHALL return 0 for every address not written since.

Reset
REQ-033 While rst_n=0: data_read=0, read_valid=0, busy=1, FSM=CLEAR, pointer=0; read pipeline flushed.
REQ-034 After rst_n deasserts, SHALL clear the whole array automatically (2**A_WIDTH cycles), then enter IDLE.
REQ-035 Reset asserted mid-clear or mid-read SHALL abort the operation, flush the pipeline, and restart the clear from pointer 0 on deassert.
REQ-036 Array contents SHALL NOT be reset asynchronously; zeroing happens only through the clear engine.

Verification
REQ-037 A_WIDTH=4, D_WIDTH=12: release rst_n -> busy=1 for exactly 16 cycles; then read addr 0xB -> data_read=0x000, read_valid after RD_LATENCY cycles.
REQ-038 Write 0xC5A to 0xB with be=2'b11, then be=2'b01 with 0x3FF -> read 0xB returns 0xCFF; be=2'b10 with 0x7xx -> returns 0x7FF.
REQ-039 Same-cycle write 0x123 and read of addr 3 holding 0xABC, be=2'b01 -> RDW_MODE=0 returns 0xABC, RDW_MODE=1 returns 0xA23.
REQ-040 Pulse clear at cycle 5 of the post-reset clear -> busy stays high until 16 cycles after the pulse; write and read attempts during busy produce no write and no read_valid.
REQ-041 RD_LATENCY=2, back-to-back reads of addresses 0..15 -> 16 consecutive read_valid cycles, data in address order, first beat 2 cycles after the first request.
REQ-042 Assert rst_n low during a read burst -> read_valid=0 and data_read=0 immediately, then a full 16-cycle clear after release.

Source files
------------

// File: rtl/ram_sdp_clr_if.sv
// Purpose: port bundle for the clearable simple-dual-port RAM (write port, read port, clear control).
// Latency: none, wires only.
// Backpressure: none; busy from the RAM tells the requester that accesses are being dropped.
interface ram_sdp_clr_if #(
    parameter int A_WIDTH = 4,
    parameter int D_WIDTH = 8
);
    localparam int BE_WIDTH = (D_WIDTH + 7) / 8;

    logic                write_enable;
    logic [A_WIDTH-1:0]  address_write;
    logic [D_WIDTH-1:0]  data_write;
    logic [BE_WIDTH-1:0] byte_enable;
    logic                read_enable;
    logic [A_WIDTH-1:0]  address_read;
    logic [D_WIDTH-1:0]  data_read;
    logic                read_valid;
    logic                clear;
    logic                busy;

    // Requester side
    modport master (
        output write_enable, address_write, data_write, byte_enable,
        output read_enable, address_read, clear,
        input  data_read, read_valid, busy
    );

    // RAM side
    modport slave (
        input  write_enable, address_write, data_write, byte_enable,
        input  read_enable, address_read, clear,
        output data_read, read_valid, busy
    );
endinterface

// File: rtl/ram_sdp_clr.sv
// Purpose: simple-dual-port RAM with byte-lane writes and a sequential zeroing engine.
// Latency: read data/valid RD_LATENCY cycles after the request; a full clear takes 2**A_WIDTH cycles.
// Backpressure: none; while busy is high all user reads and writes are silently dropped.
module ram_sdp_clr #(
    parameter int A_WIDTH    = 4,
    parameter int D_WIDTH    = 8,
    parameter int RD_LATENCY = 1,   // 1 or 2
    parameter int RDW_MODE   = 0    // 0: old data, 1: new data on same-address collision
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_sdp_clr_if.slave  bus
);
    localparam int DEPTH    = 2 ** A_WIDTH;
    localparam int BE_WIDTH = (D_WIDTH + 7) / 8;
    localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] ptr_q, ptr_d;
    logic               clr_we;

    logic [D_WIDTH-1:0] mem [DEPTH];

    logic               user_wr, user_rd;
    logic [D_WIDTH-1:0] wmask;
    logic [D_WIDTH-1:0] wr_old, wr_new;
    logic [D_WIDTH-1:0] rd_word;

    logic               out_vld;
    logic [D_WIDTH-1:0] out_dat;
    logic               read_valid_q;
    logic [D_WIDTH-1:0] data_read_q;

    // Expand the lane mask to bit granularity; the top lane may be partial
    for (genvar i = 0; i < D_WIDTH; i++) begin : g_mask
        assign wmask[i] = bus.byte_enable[i / 8];
    end

    // User accesses only count while the clear engine is parked
    assign user_wr = (state_q == IDLE) && bus.write_enable;
    assign user_rd = (state_q == IDLE) && bus.read_enable;

    assign wr_old = mem[bus.address_write];
    assign wr_new = (wr_old & ~wmask) | (bus.data_write & wmask);

    // Collision handling: optionally forward the merged write word to the reader
    always_comb begin
        rd_word = mem[bus.address_read];
        if ((RDW_MODE == 1) && user_wr && (bus.address_write == bus.address_read)) begin
            rd_word = wr_new;
        end
    end

    // Clear FSM state and pointer; reset parks the engine at the start of a fresh clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Clear FSM next state: one word per cycle, single pass, clear pulses restart from zero
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        clr_we  = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                if (bus.clear) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                    if (ptr_q == LAST_ADDR) begin
                        state_d = IDLE;
                    end
                end
            end
            IDLE: begin
                if (bus.clear) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    // Array write port; contents are never reset, only zeroed by the clear engine
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[ptr_q] <= '0;
        end else if (user_wr) begin
            mem[bus.address_write] <= wr_new;
        end
    end

    // Optional extra pipeline stage between the array and the output register
    if (RD_LATENCY == 2) begin : g_lat2
        logic               p1_vld;
        logic [D_WIDTH-1:0] p1_dat;

        // Stage-1 read register
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                p1_vld <= 1'b0;
                p1_dat <= '0;
            end else begin
                p1_vld <= user_rd;
                if (user_rd) begin
                    p1_dat <= rd_word;
                end
            end
        end

        assign out_vld = p1_vld;
        assign out_dat = p1_dat;
    end else begin : g_lat1
        assign out_vld = user_rd;
        assign out_dat = rd_word;
    end

    // Output register: data only moves on a valid beat so it holds between beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_valid_q <= 1'b0;
            data_read_q  <= '0;
        end else begin
            read_valid_q <= out_vld;
            if (out_vld) begin
                data_read_q <= out_dat;
            end
        end
    end

    assign bus.read_valid = read_valid_q;
    assign bus.data_read  = data_read_q;
    assign bus.busy       = (state_q == CLEAR);
endmodule

// File: tb/tb_ram_sdp_clr.sv
module tb_ram_sdp_clr;
    localparam int AW = 4;
    localparam int DW = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           we, re, clr;
    logic [AW-1:0]  aw, ar;
    logic [DW-1:0]  dw;
    logic [1:0]     be;

    // dut0: latency 1, old-data collisions; dut1: latency 2, new-data collisions
    ram_sdp_clr_if #(.A_WIDTH(AW), .D_WIDTH(DW)) ifc0 ();
    ram_sdp_clr_if #(.A_WIDTH(AW), .D_WIDTH(DW)) ifc1 ();

    assign ifc0.write_enable  = we;  assign ifc1.write_enable  = we;
    assign ifc0.address_write = aw;  assign ifc1.address_write = aw;
    assign ifc0.data_write    = dw;  assign ifc1.data_write    = dw;
    assign ifc0.byte_enable   = be;  assign ifc1.byte_enable   = be;
    assign ifc0.read_enable   = re;  assign ifc1.read_enable   = re;
    assign ifc0.address_read  = ar;  assign ifc1.address_read  = ar;
    assign ifc0.clear         = clr; assign ifc1.clear         = clr;

    ram_sdp_clr #(.A_WIDTH(AW), .D_WIDTH(DW), .RD_LATENCY(1), .RDW_MODE(0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(ifc0));
    ram_sdp_clr #(.A_WIDTH(AW), .D_WIDTH(DW), .RD_LATENCY(2), .RDW_MODE(1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1));

    int n_pass = 0;
    int n_total = 0;

    typedef enum logic [1:0] { OP_WR, OP_RD, OP_RDW } op_t;
    typedef struct {
        op_t          op;
        logic [1:0]   be;
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
        logic [DW-1:0] exp0;
        logic [DW-1:0] exp1;
    } vec_t;

    vec_t vt [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        return 12'h05A ^ (12'(i) * 12'h111);
    endfunction

    task automatic do_write(input logic [AW-1:0] a, input logic [1:0] b, input logic [DW-1:0] d);
        we = 1'b1; aw = a; be = b; dw = d;
        tick();
        we = 1'b0;
    endtask

    // Read (optionally with a same-address write) and check both latencies
    task automatic do_read(input string nm, input logic [AW-1:0] a, input logic [DW-1:0] e0,
                           input logic [DW-1:0] e1, input logic wr_too,
                           input logic [1:0] b, input logic [DW-1:0] d);
        re = 1'b1; ar = a;
        if (wr_too) begin
            we = 1'b1; aw = a; be = b; dw = d;
        end
        tick();
        re = 1'b0; we = 1'b0;
        chk({nm, " rv0"}, 32'(ifc0.read_valid), 32'd1);
        chk({nm, " dr0"}, 32'(ifc0.data_read), 32'(e0));
        chk({nm, " rv1 early"}, 32'(ifc1.read_valid), 32'd0);
        tick();
        chk({nm, " rv1"}, 32'(ifc1.read_valid), 32'd1);
        chk({nm, " dr1"}, 32'(ifc1.data_read), 32'(e1));
        chk({nm, " rv0 strobe"}, 32'(ifc0.read_valid), 32'd0);
    endtask

    // Step until dut0 leaves CLEAR (bounded), counting cycles and any read beats seen
    task automatic wait_idle(output int n, output int v0, output int v1, output logic [DW-1:0] d1);
        n = 0; v0 = 0; v1 = 0; d1 = '0;
        while (ifc0.busy && n < 40) begin
            tick();
            n++;
            if (ifc0.read_valid) v0++;
            if (ifc1.read_valid) begin
                v1++;
                d1 = ifc1.data_read;
            end
        end
    endtask

    initial begin
        int n, v0, v1;
        logic [DW-1:0] d1;

        we = 0; re = 0; clr = 0; aw = '0; ar = '0; dw = '0; be = '0;

        vt[0]  = '{OP_RD,  2'b00, 4'hB, 12'h000, 12'h000, 12'h000};
        vt[1]  = '{OP_WR,  2'b11, 4'hB, 12'hC5A, 12'h000, 12'h000};
        vt[2]  = '{OP_RD,  2'b00, 4'hB, 12'h000, 12'hC5A, 12'hC5A};
        vt[3]  = '{OP_WR,  2'b01, 4'hB, 12'h3FF, 12'h000, 12'h000};
        vt[4]  = '{OP_RD,  2'b00, 4'hB, 12'h000, 12'hCFF, 12'hCFF};
        vt[5]  = '{OP_WR,  2'b10, 4'hB, 12'h7AB, 12'h000, 12'h000};
        vt[6]  = '{OP_RD,  2'b00, 4'hB, 12'h000, 12'h7FF, 12'h7FF};
        vt[7]  = '{OP_WR,  2'b00, 4'hB, 12'h123, 12'h000, 12'h000};
        vt[8]  = '{OP_RD,  2'b00, 4'hB, 12'h000, 12'h7FF, 12'h7FF};
        vt[9]  = '{OP_WR,  2'b11, 4'h3, 12'hABC, 12'h000, 12'h000};
        vt[10] = '{OP_RDW, 2'b01, 4'h3, 12'h123, 12'hABC, 12'hA23};
        vt[11] = '{OP_RD,  2'b00, 4'h3, 12'h000, 12'hA23, 12'hA23};
        vt[12] = '{OP_RD,  2'b00, 4'h0, 12'h000, 12'h000, 12'h000};
        vt[13] = '{OP_WR,  2'b11, 4'hF, 12'hFFF, 12'h000, 12'h000};
        vt[14] = '{OP_RD,  2'b00, 4'hF, 12'h000, 12'hFFF, 12'hFFF};
        vt[15] = '{OP_RD,  2'b00, 4'h5, 12'h000, 12'h000, 12'h000};

        // Reset state
        tick(); tick();
        chk("rst busy0", 32'(ifc0.busy), 32'd1);
        chk("rst busy1", 32'(ifc1.busy), 32'd1);
        chk("rst rv0", 32'(ifc0.read_valid), 32'd0);
        chk("rst rv1", 32'(ifc1.read_valid), 32'd0);
        chk("rst dr0", 32'(ifc0.data_read), 32'd0);
        chk("rst dr1", 32'(ifc1.data_read), 32'd0);

        // Post-reset automatic clear
        rst_n = 1'b1;
        wait_idle(n, v0, v1, d1);
        chk("init clear cycles", 32'(n), 32'd16);
        chk("init busy1 low", 32'(ifc1.busy), 32'd0);

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            case (vt[i].op)
                OP_WR:  do_write(vt[i].addr, vt[i].be, vt[i].dat);
                OP_RD:  do_read($sformatf("vec%0d", i), vt[i].addr, vt[i].exp0, vt[i].exp1,
                                1'b0, 2'b00, '0);
                default: do_read($sformatf("vec%0d rdw", i), vt[i].addr, vt[i].exp0, vt[i].exp1,
                                 1'b1, vt[i].be, vt[i].dat);
            endcase
        end

        // Back-to-back burst over the whole array
        for (int i = 0; i < 16; i++) do_write(AW'(i), 2'b11, pat(i));
        for (int c = 1; c <= 18; c++) begin
            re = (c <= 16);
            ar = AW'(c - 1);
            tick();
            chk($sformatf("burst c%0d rv0", c), 32'(ifc0.read_valid), 32'(c <= 16));
            chk($sformatf("burst c%0d dr0", c), 32'(ifc0.data_read), 32'(pat((c <= 16) ? c - 1 : 15)));
            chk($sformatf("burst c%0d rv1", c), 32'(ifc1.read_valid), 32'(c >= 2 && c <= 17));
            if (c >= 2)
                chk($sformatf("burst c%0d dr1", c), 32'(ifc1.data_read), 32'(pat((c <= 17) ? c - 2 : 15)));
        end
        re = 1'b0;

        // Clear from IDLE with a read in flight
        re = 1'b1; ar = 4'h5; clr = 1'b1;
        tick();
        re = 1'b0; clr = 1'b0;
        chk("flight rv0", 32'(ifc0.read_valid), 32'd1);
        chk("flight dr0", 32'(ifc0.data_read), 32'(pat(5)));
        chk("flight busy0", 32'(ifc0.busy), 32'd1);
        chk("flight busy1", 32'(ifc1.busy), 32'd1);
        wait_idle(n, v0, v1, d1);
        chk("flight clear cycles", 32'(n), 32'd16);
        chk("flight rv0 during busy", 32'(v0), 32'd0);
        chk("flight rv1 beats", 32'(v1), 32'd1);
        chk("flight dr1", 32'(d1), 32'(pat(5)));
        do_read("after clr a5", 4'h5, 12'h000, 12'h000, 1'b0, 2'b00, '0);
        do_read("after clr aF", 4'hF, 12'h000, 12'h000, 1'b0, 2'b00, '0);

        // Reset in the middle of a read burst
        for (int i = 0; i < 4; i++) do_write(AW'(i), 2'b11, pat(i));
        re = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ar = AW'(i);
            tick();
        end
        chk("pre-rst dr0", 32'(ifc0.data_read), 32'(pat(2)));
        chk("pre-rst dr1", 32'(ifc1.data_read), 32'(pat(1)));
        #2 rst_n = 1'b0;
        #1;
        chk("mid rst rv0", 32'(ifc0.read_valid), 32'd0);
        chk("mid rst dr0", 32'(ifc0.data_read), 32'd0);
        chk("mid rst rv1", 32'(ifc1.read_valid), 32'd0);
        chk("mid rst dr1", 32'(ifc1.data_read), 32'd0);
        chk("mid rst busy0", 32'(ifc0.busy), 32'd1);
        re = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        wait_idle(n, v0, v1, d1);
        chk("rst2 clear cycles", 32'(n), 32'd16);
        do_read("after rst2 a2", 4'h2, 12'h000, 12'h000, 1'b0, 2'b00, '0);

        // Clear pulse at cycle 5 of the post-reset clear, accesses hammered while busy
        do_write(4'h0, 2'b11, 12'h777);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("c5 still busy", 32'(ifc0.busy), 32'd1);
        clr = 1'b1; we = 1'b1; aw = 4'h0; be = 2'b11; dw = 12'h5A5; re = 1'b1; ar = 4'h0;
        tick();
        clr = 1'b0;
        chk("c5 pulse rv0", 32'(ifc0.read_valid), 32'd0);
        wait_idle(n, v0, v1, d1);
        we = 1'b0; re = 1'b0;
        chk("c5 restart cycles", 32'(n), 32'd16);
        chk("c5 rv0 during busy", 32'(v0), 32'd0);
        chk("c5 rv1 during busy", 32'(v1), 32'd0);
        do_read("c5 a0 unwritten", 4'h0, 12'h000, 12'h000, 1'b0, 2'b00, '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
